// File: rtl/glb_psum_writeback.sv
// GLB psum write-back initiator: streams PE-array psums into the psum bank, read-modify-write
// (accumulate) or plain write per job. Define GLB_PSUM_SAT_EN for a signed saturating accumulate.
module glb_psum_writeback #(
  parameter int DATA_BITWIDTH = 32,
  parameter int BANK_NUM      = 3,
  parameter int BANK_DEPTH    = 8192,
  parameter int PSUM_BANK     = 1,
  parameter int RD_LATENCY    = 2,
  localparam int BSEL_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
  localparam int AW     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [AW-1:0]            i_base_addr,
  input  logic [AW:0]              i_count,
  input  logic                     i_accumulate,
  input  logic                     i_psum_valid,
  output logic                     o_psum_ready,
  input  logic [DATA_BITWIDTH-1:0] i_psum_data,
  output logic [BSEL_W-1:0]        o_glb_bank_sel,
  output logic                     o_glb_re,
  output logic [AW-1:0]            o_glb_ra,
  input  logic [DATA_BITWIDTH-1:0] i_glb_rd,
  output logic                     o_glb_we,
  output logic [AW-1:0]            o_glb_wa,
  output logic [DATA_BITWIDTH-1:0] o_glb_wd,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int DW = DATA_BITWIDTH;
  localparam int PL = RD_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]          state;
  logic [AW-1:0]       cur_addr;
  logic [AW:0]         count_q;
  logic [AW:0]         accepted;
  logic                acc_mode;
  logic                accept;
  logic [PL:0]         pipe_v;
  logic [PL:0][AW-1:0] pipe_a;
  logic [PL:0][DW-1:0] pipe_d;
  logic [DW-1:0]       add_res;

  assign o_glb_bank_sel = BSEL_W'(PSUM_BANK);
  assign o_psum_ready   = (state == S_RUN) && (accepted < count_q);
  assign accept         = i_psum_valid && o_psum_ready;
  assign o_busy         = (state == S_RUN) || (state == S_DRAIN);
  assign o_done         = (state == S_DONE);

`ifdef GLB_PSUM_SAT_EN
  logic [DW:0] sum_ext;

  always_comb begin
    sum_ext = {pipe_d[PL][DW-1], pipe_d[PL]} + {i_glb_rd[DW-1], i_glb_rd};
    add_res = sum_ext[DW-1:0];
    // sign bits disagree only on overflow; the extended sign picks the clamp direction
    if (sum_ext[DW] != sum_ext[DW-1])
      add_res = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  always_comb begin
    add_res = pipe_d[PL] + i_glb_rd;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      count_q  <= '0;
      accepted <= '0;
      acc_mode <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          cur_addr <= i_base_addr;
          count_q  <= i_count;
          accepted <= '0;
          acc_mode <= i_accumulate;
          state    <= (i_count == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (accept) begin
          accepted <= accepted + 1'b1;
          cur_addr <= (cur_addr == AW'(BANK_DEPTH - 1)) ? '0 : cur_addr + 1'b1;
          if (accepted + 1'b1 == count_q) state <= S_DRAIN;
        end
        S_DRAIN: if (pipe_v == '0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage PL lines up with the GLB read data; the GLB never stalls, so a plain shift suffices.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pipe_v   <= '0;
      pipe_a   <= '0;
      pipe_d   <= '0;
      o_glb_re <= 1'b0;
      o_glb_ra <= '0;
      o_glb_we <= 1'b0;
      o_glb_wa <= '0;
      o_glb_wd <= '0;
    end else begin
      pipe_v   <= {pipe_v[PL-1:0], accept};
      pipe_a   <= {pipe_a[PL-1:0], cur_addr};
      pipe_d   <= {pipe_d[PL-1:0], i_psum_data};
      o_glb_re <= accept && acc_mode;
      if (accept) o_glb_ra <= cur_addr;
      o_glb_we <= pipe_v[PL];
      if (pipe_v[PL]) begin
        o_glb_wa <= pipe_a[PL];
        o_glb_wd <= acc_mode ? add_res : pipe_d[PL];
      end
    end
  end

endmodule

// File: tb/tb_glb_psum_writeback.sv
// Scoreboard bench for glb_psum_writeback with a behavioural 2-cycle-latency GLB bank model.
module tb_glb_psum_writeback;
  localparam int DW = 32, AW = 13, DEPTH = 8192, LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW:0]   i_count = '0;
  logic          i_accumulate = 1'b0;
  logic          i_psum_valid = 1'b0;
  logic          o_psum_ready;
  logic [DW-1:0] i_psum_data = '0;
  logic [1:0]    o_glb_bank_sel;
  logic          o_glb_re, o_glb_we, o_busy, o_done;
  logic [AW-1:0] o_glb_ra, o_glb_wa;
  logic [DW-1:0] i_glb_rd, o_glb_wd;

  always #5 clk = ~clk;

  glb_psum_writeback #(
    .DATA_BITWIDTH(DW), .BANK_NUM(3), .BANK_DEPTH(DEPTH), .PSUM_BANK(1), .RD_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .i_accumulate(i_accumulate), .i_psum_valid(i_psum_valid),
    .o_psum_ready(o_psum_ready), .i_psum_data(i_psum_data), .o_glb_bank_sel(o_glb_bank_sel),
    .o_glb_re(o_glb_re), .o_glb_ra(o_glb_ra), .i_glb_rd(i_glb_rd), .o_glb_we(o_glb_we),
    .o_glb_wa(o_glb_wa), .o_glb_wd(o_glb_wd), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [DW-1:0] rd_s1;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  int            cyc = 0;

  wr_t           we_log[$];
  logic [AW-1:0] re_log[$];
  int            done_log[$];
  bit            busy_ok_log[$];
  bit            prev_busy = 1'b0;

  wr_t           exp_q[$];
  logic [DW-1:0] stim_q[$];
  logic [AW-1:0] cur_base;
  bit            cur_acc;
  int            n_checks = 0, n_fail = 0, we_rd = 0;

  // GLB bank: registered read with two cycles from re to data
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_s1 <= o_glb_re ? mem[o_glb_ra] : 32'hDEAD_BEEF;
    i_glb_rd <= rd_s1;
    if (o_glb_we) mem[o_glb_wa] <= o_glb_wd;
    if (pre_we) mem[pre_a] <= pre_d;
  end

  always @(negedge clk) begin
    if (o_glb_we) we_log.push_back(wr_t'{o_glb_wa, o_glb_wd, cyc});
    if (o_glb_re) re_log.push_back(o_glb_ra);
    if (o_done) begin
      done_log.push_back(cyc);
      busy_ok_log.push_back(prev_busy && !o_busy);
    end
    prev_busy = o_busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
`ifdef GLB_PSUM_SAT_EN
    if (s[DW] != s[DW-1]) return s[DW] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s[DW-1:0];
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW:0] cnt, input bit acc);
    i_start = 1'b1; i_base_addr = base; i_count = cnt; i_accumulate = acc;
    cur_base = base; cur_acc = acc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic stream(input bit bubble);
    int sent;
    int k;
    logic [AW-1:0] a;
    sent = 0; k = 0;
    while (sent < stim_q.size() && k < 100) begin
      i_psum_valid = !bubble || (k % 2 == 0);
      i_psum_data  = stim_q[sent];
      @(negedge clk);
      if (i_psum_valid && o_psum_ready) begin
        a = AW'((int'(cur_base) + sent) % DEPTH);
        exp_q.push_back(wr_t'{a, cur_acc ? ref_add(mem[a], stim_q[sent]) : stim_q[sent], cyc + LAT + 2});
        sent++;
      end
      @(posedge clk); #1;
      k++;
    end
    i_psum_valid = 1'b0;
    if (sent < stim_q.size()) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: accepted %0d, required %0d", sent, stim_q.size());
    end
  endtask

  task automatic wait_idle(input int n0);
    int k;
    k = 0;
    while (done_log.size() <= n0 && k < 100) begin @(negedge clk); k++; end
    if (done_log.size() <= n0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: no o_done within %0d cycles", k);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    n_checks++;
    if ({o_glb_re, o_glb_we, o_psum_ready, o_busy, o_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b, required 00000", {o_glb_re, o_glb_we, o_psum_ready, o_busy, o_done});
    end
    n_checks++;
    if (o_glb_ra !== '0 || o_glb_wa !== '0 || o_glb_wd !== '0) begin
      n_fail++; $display("FAIL reset_bus: got ra=%0h wa=%0h wd=%0h, required 0", o_glb_ra, o_glb_wa, o_glb_wd);
    end
    n_checks++;
    if (o_glb_bank_sel !== 2'd1) begin
      n_fail++; $display("FAIL bank_sel: got %0d, required 1", o_glb_bank_sel);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({o_busy, o_psum_ready, o_done} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, required 000", {o_busy, o_psum_ready, o_done});
    end
  endtask

  task automatic test_overwrite();
    int n0, r0;
    wr_t e, w;
    n0 = done_log.size(); r0 = re_log.size();
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    start_job(13'h10, 14'd4, 1'b0);
    stream(1'b0);
    wait_idle(n0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL ovw_write: write missing, required wa=%0h wd=%0h @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL ovw_write: got wa=%0h wd=%0h @%0d, required wa=%0h wd=%0h @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
    n_checks++;
    if (we_rd != we_log.size()) begin n_fail++; $display("FAIL ovw_extra: %0d writes, required %0d", we_log.size(), we_rd); end
    n_checks++;
    if (re_log.size() != r0) begin n_fail++; $display("FAIL ovw_no_re: %0d reads, required 0", re_log.size() - r0); end
    n_checks++;
    if (done_log.size() != n0 + 1 || we_rd == 0 || done_log[n0] != we_log[we_rd-1].c + 1) begin
      n_fail++; $display("FAIL ovw_done: got %0d pulses last @%0d, required 1 @ last we + 1", done_log.size() - n0, done_log[$]);
    end
  endtask

  task automatic test_accumulate();
    int n0, r0;
    wr_t e, w;
    preload(13'h20, 32'd100); preload(13'h21, 32'd200); preload(13'h22, 32'd300);
    n0 = done_log.size(); r0 = re_log.size();
    stim_q = '{32'd1, 32'd2, 32'd3};
    start_job(13'h20, 14'd3, 1'b1);
    stream(1'b0);
    wait_idle(n0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL acc_write: write missing, required wa=%0h wd=%0d @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL acc_write: got wa=%0h wd=%0d @%0d, required wa=%0h wd=%0d @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
    n_checks++;
    if (we_rd != we_log.size()) begin n_fail++; $display("FAIL acc_extra: %0d writes, required %0d", we_log.size(), we_rd); end
    n_checks++;
    if (re_log.size() != r0 + 3 || re_log[r0] !== 13'h20 || re_log[r0+1] !== 13'h21 || re_log[r0+2] !== 13'h22) begin
      n_fail++; $display("FAIL acc_reads: got %0d reads starting %0h, required 3 at 20,21,22", re_log.size() - r0, re_log[r0]);
    end
    n_checks++;
    if (mem[13'h21] !== 32'd202) begin n_fail++; $display("FAIL acc_mem: got %0d, required 202", mem[13'h21]); end
    n_checks++;
    if (busy_ok_log.size() == 0 || busy_ok_log[$] !== 1'b1) begin
      n_fail++; $display("FAIL acc_busy_fall: busy did not fall with o_done");
    end
  endtask

  task automatic test_bubbles();
    int n0;
    wr_t e, w;
    n0 = done_log.size();
    stim_q = '{32'hA5, 32'h5A};
    start_job(13'h100, 14'd2, 1'b0);
    stream(1'b1);
    @(negedge clk);
    n_checks++;
    if (o_psum_ready !== 1'b0) begin n_fail++; $display("FAIL bub_ready: got %b, required 0", o_psum_ready); end
    @(posedge clk); #1;
    wait_idle(n0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL bub_write: write missing, required wa=%0h wd=%0h @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL bub_write: got wa=%0h wd=%0h @%0d, required wa=%0h wd=%0h @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
    n_checks++;
    if (we_rd != we_log.size() || we_rd < 2 || we_log[we_rd-1].c - we_log[we_rd-2].c != 2) begin
      n_fail++; $display("FAIL bub_gap: write gap or count wrong (%0d writes), required gap 2", we_log.size());
    end
  endtask

  task automatic test_wrap();
    int n0;
    wr_t e, w;
    logic [AW-1:0] want [4];
    want = '{13'd8190, 13'd8191, 13'd0, 13'd1};
    preload(13'd8190, 32'd5); preload(13'd8191, 32'd6); preload(13'd0, 32'd7); preload(13'd1, 32'd8);
    n0 = done_log.size();
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    start_job(13'd8190, 14'd4, 1'b1);
    stream(1'b0);
    wait_idle(n0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (we_rd + i >= we_log.size() || we_log[we_rd+i].a !== want[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %0d, required %0d", i, we_log[we_rd+i].a, want[i]);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL wrap_write: write missing, required wa=%0d wd=%0d @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL wrap_write: got wa=%0d wd=%0d @%0d, required wa=%0d wd=%0d @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
    n_checks++;
    if (we_rd != we_log.size()) begin n_fail++; $display("FAIL wrap_extra: %0d writes, required %0d", we_log.size(), we_rd); end
  endtask

  task automatic test_zero_and_busy();
    int n0, r0, w0, sc, k;
    wr_t e, w;
    n0 = done_log.size(); r0 = re_log.size(); w0 = we_log.size();
    sc = cyc;
    start_job(13'h50, 14'd0, 1'b1);
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (done_log.size() != n0 + 1 || done_log[n0] != sc + 1) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses @%0d, required 1 @%0d", done_log.size() - n0, done_log[$], sc + 1);
    end
    n_checks++;
    if (we_log.size() != w0 || re_log.size() != r0) begin
      n_fail++; $display("FAIL zero_access: got %0d we %0d re, required 0", we_log.size() - w0, re_log.size() - r0);
    end
    n0 = done_log.size();
    stim_q = '{32'd10, 32'd20, 32'd30};
    start_job(13'h40, 14'd3, 1'b0);
    i_start = 1'b1; i_base_addr = 13'h80; i_count = 14'd1; i_accumulate = 1'b1;
    stream(1'b0);
    i_start = 1'b0;
    k = 0;
    while (!o_done && k < 50) begin @(negedge clk); k++; end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk); #1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL busy_write: write missing, required wa=%0h wd=%0d @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL busy_write: got wa=%0h wd=%0d @%0d, required wa=%0h wd=%0d @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
    n_checks++;
    if (we_rd != we_log.size()) begin n_fail++; $display("FAIL busy_extra: %0d writes, required %0d", we_log.size(), we_rd); end
    n_checks++;
    if (o_busy !== 1'b0 || done_log.size() != n0 + 1) begin
      n_fail++; $display("FAIL start_at_done: busy=%b pulses=%0d, required busy=0 pulses=1", o_busy, done_log.size() - n0);
    end
  endtask

  task automatic test_overflow();
    int n0;
    wr_t e, w;
    logic [DW-1:0] want_hi, want_lo;
`ifdef GLB_PSUM_SAT_EN
    want_hi = 32'h7FFF_FFFF; want_lo = 32'h8000_0000;
`else
    want_hi = 32'h8000_0000; want_lo = 32'h7FFF_FFFF;
`endif
    preload(13'h30, 32'h7FFF_FFFF); preload(13'h31, 32'h8000_0000);
    n0 = done_log.size();
    stim_q = '{32'd1, 32'hFFFF_FFFF};
    start_job(13'h30, 14'd2, 1'b1);
    stream(1'b0);
    wait_idle(n0);
    n_checks++;
    if (we_rd + 1 >= we_log.size() || we_log[we_rd].d !== want_hi || we_log[we_rd+1].d !== want_lo) begin
      n_fail++; $display("FAIL ovf_value: got %0h %0h, required %0h %0h", we_log[we_rd].d, we_log[we_rd+1].d, want_hi, want_lo);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (we_rd >= we_log.size()) begin
        n_fail++; $display("FAIL ovf_write: write missing, required wa=%0h wd=%0h @%0d", e.a, e.d, e.c);
      end else begin
        w = we_log[we_rd]; we_rd++;
        if (w.a !== e.a || w.d !== e.d || w.c != e.c) begin
          n_fail++; $display("FAIL ovf_write: got wa=%0h wd=%0h @%0d, required wa=%0h wd=%0h @%0d", w.a, w.d, w.c, e.a, e.d, e.c);
        end
      end
    end
  endtask

  task automatic test_reset_midjob();
    int w0, r0;
    start_job(13'h200, 14'd4, 1'b1);
    i_psum_valid = 1'b1; i_psum_data = 32'd9;
    repeat (2) @(posedge clk);
    #2;
    i_psum_valid = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", o_busy); end
    w0 = we_log.size();
    rst_n = 1'b0; #1;
    r0 = re_log.size();
    n_checks++;
    if ({o_glb_re, o_glb_we, o_psum_ready, o_busy, o_done} !== 5'b0 || o_glb_ra !== '0 || o_glb_wa !== '0 || o_glb_wd !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got re=%b we=%b rdy=%b busy=%b ra=%0h, required all 0", o_glb_re, o_glb_we, o_psum_ready, o_busy, o_glb_ra);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    n_checks++;
    if (we_log.size() != w0 || re_log.size() != r0) begin
      n_fail++; $display("FAIL mid_reset_access: got %0d we %0d re after reset, required 0", we_log.size() - w0, re_log.size() - r0);
    end
    exp_q.delete();
    we_rd = we_log.size();
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accumulate();
    test_bubbles();
    test_wrap();
    test_zero_and_busy();
    test_overflow();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
